dac_drive_seq: RTL and testbench

Sequencer and code formatter in front of the DAC `driver_cell`. It runs the power-up and power-down sequence on `pdb` and gates operation on a supply-good indication. During operation it accepts a 13-bit segmented DAC code over a valid/ready handshake and splits it into 8 binary LSBs plus a 17-segment thermometer word, with complements. All outputs are registered, so the driver sees glitch-free, simultaneous updates.

---
 rtl/dac_drive_seq.sv | 169 ++++++++++++++++
 tb/tb_dac_drive_seq.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/dac_drive_seq.sv
// Power sequencer and segmented-code formatter in front of the DAC driver_cell.
// Every output is a flop, so the driver sees simultaneous, glitch-free updates.
module dac_drive_seq #(
  parameter int unsigned PWRUP_CYCLES = 16,
  parameter int unsigned PWRDN_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        supply_ok,
  input  logic        fault_clr,
  input  logic        s_valid,
  input  logic [12:0] s_code,
  output logic        s_ready,
  output logic        pdb,
  output logic [7:0]  datain,
  output logic [7:0]  datainb,
  output logic [16:0] datatherm,
  output logic [16:0] datathermb,
  output logic        sat,
  output logic        fault,
  output logic        busy,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_PWRUP  = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_PWRDN  = 2'd3
  } state_t;

  // The counter is loaded with N-1 on entry so the state lasts exactly N cycles.
  localparam logic [7:0] PWRUP_LOAD = 8'(PWRUP_CYCLES - 1);
  localparam logic [7:0] PWRDN_LOAD = 8'(PWRDN_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        fault_q, fault_d;
  logic        sat_q, sat_d;
  logic        s_ready_q, s_ready_d;
  logic        pdb_q, pdb_d;
  logic        busy_q, busy_d;
  logic [7:0]  datain_q, datain_d;
  logic [7:0]  datainb_q, datainb_d;
  logic [16:0] datatherm_q, datatherm_d;
  logic [16:0] datathermb_q, datathermb_d;

  logic [4:0]  fmt_t;
  logic        fmt_clamp;
  logic [7:0]  fmt_bin;
  logic [16:0] fmt_therm;

  always_comb begin
    fmt_clamp = (s_code[12:8] > 5'd17);
    fmt_t     = fmt_clamp ? 5'd17 : s_code[12:8];
    fmt_bin   = fmt_clamp ? 8'hFF : s_code[7:0];
    fmt_therm = '0;
    for (int i = 0; i < 17; i++) begin
      fmt_therm[i] = (5'(i) < fmt_t);
    end
  end

  // Handshake: a code transfers on any rising edge where s_valid && s_ready.
  // s_ready is a flop of the state; a transfer coinciding with en=0 or a
  // supply loss is accepted but immediately replaced by the zero code.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fault_d     = fault_clr ? 1'b0 : fault_q;
    sat_d       = 1'b0;
    datain_d    = datain_q;
    datatherm_d = datatherm_q;

    case (state_q)
      ST_OFF: begin
        if (en && supply_ok && !fault_q) begin
          state_d = ST_PWRUP;
          cnt_d   = PWRUP_LOAD;
        end
      end
      ST_PWRUP: begin
        if (!en) begin
          state_d = ST_PWRDN;
          cnt_d   = PWRDN_LOAD;
        end else if (cnt_q == 8'd0) begin
          state_d = ST_ACTIVE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_ACTIVE: begin
        if (!en) begin
          state_d = ST_PWRDN;
          cnt_d   = PWRDN_LOAD;
        end else if (s_valid && s_ready_q) begin
          datain_d    = fmt_bin;
          datatherm_d = fmt_therm;
          sat_d       = fmt_clamp;
        end
      end
      default: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_OFF;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
    endcase

    // Supply loss wins over everything, including a same-cycle fault_clr.
    if (state_q != ST_OFF && !supply_ok) begin
      state_d = ST_OFF;
      fault_d = 1'b1;
      sat_d   = 1'b0;
    end

    if (state_d != ST_ACTIVE) begin
      datain_d    = 8'h00;
      datatherm_d = 17'h0;
    end

    datainb_d    = ~datain_d;
    datathermb_d = ~datatherm_d;
    pdb_d        = (state_d != ST_OFF);
    busy_d       = (state_d != ST_OFF);
    s_ready_d    = (state_d == ST_ACTIVE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_OFF;
      cnt_q        <= 8'd0;
      fault_q      <= 1'b0;
      sat_q        <= 1'b0;
      s_ready_q    <= 1'b0;
      pdb_q        <= 1'b0;
      busy_q       <= 1'b0;
      datain_q     <= 8'h00;
      datainb_q    <= 8'hFF;
      datatherm_q  <= 17'h0;
      datathermb_q <= 17'h1FFFF;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fault_q      <= fault_d;
      sat_q        <= sat_d;
      s_ready_q    <= s_ready_d;
      pdb_q        <= pdb_d;
      busy_q       <= busy_d;
      datain_q     <= datain_d;
      datainb_q    <= datainb_d;
      datatherm_q  <= datatherm_d;
      datathermb_q <= datathermb_d;
    end
  end

  assign s_ready    = s_ready_q;
  assign pdb        = pdb_q;
  assign datain     = datain_q;
  assign datainb    = datainb_q;
  assign datatherm  = datatherm_q;
  assign datathermb = datathermb_q;
  assign sat        = sat_q;
  assign fault      = fault_q;
  assign busy       = busy_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_dac_drive_seq.sv
// Directed bench for dac_drive_seq: power sequencing, code mapping, clamping,
// supply fault handling and mid-sequence reset.
module tb_dac_drive_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        supply_ok;
  logic        fault_clr;
  logic        s_valid;
  logic [12:0] s_code;
  logic        s_ready;
  logic        pdb;
  logic [7:0]  datain;
  logic [7:0]  datainb;
  logic [16:0] datatherm;
  logic [16:0] datathermb;
  logic        sat;
  logic        fault;
  logic        busy;
  logic [1:0]  state_dbg;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dac_drive_seq #(.PWRUP_CYCLES(16), .PWRDN_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .en(en), .supply_ok(supply_ok), .fault_clr(fault_clr),
    .s_valid(s_valid), .s_code(s_code), .s_ready(s_ready), .pdb(pdb),
    .datain(datain), .datainb(datainb), .datatherm(datatherm), .datathermb(datathermb),
    .sat(sat), .fault(fault), .busy(busy), .state_dbg(state_dbg)
  );

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; supply_ok = 1'b1; fault_clr = 1'b0;
    s_valid = 1'b0; s_code = '0;
    step(); step();
    rst = 1'b0;
    total++; if (pdb !== 1'b0)            begin bad++; $display("FAIL reset_pdb got=%b exp=0", pdb); end
    total++; if (s_ready !== 1'b0)        begin bad++; $display("FAIL reset_ready got=%b exp=0", s_ready); end
    total++; if (busy !== 1'b0)           begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (sat !== 1'b0)            begin bad++; $display("FAIL reset_sat got=%b exp=0", sat); end
    total++; if (fault !== 1'b0)          begin bad++; $display("FAIL reset_fault got=%b exp=0", fault); end
    total++; if (datain !== 8'h00)        begin bad++; $display("FAIL reset_datain got=%h exp=00", datain); end
    total++; if (datainb !== 8'hFF)       begin bad++; $display("FAIL reset_datainb got=%h exp=ff", datainb); end
    total++; if (datatherm !== 17'h0)     begin bad++; $display("FAIL reset_therm got=%h exp=0", datatherm); end
    total++; if (datathermb !== 17'h1FFFF) begin bad++; $display("FAIL reset_thermb got=%h exp=1ffff", datathermb); end
  endtask

  task automatic test_power_up();
    en = 1'b1;
    step();
    total++; if (pdb !== 1'b1)     begin bad++; $display("FAIL pwrup_pdb_rise got=%b exp=1", pdb); end
    total++; if (busy !== 1'b1)    begin bad++; $display("FAIL pwrup_busy got=%b exp=1", busy); end
    for (int k = 1; k < 16; k++) begin
      step();
      total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL pwrup_ready_early cyc=%0d got=%b exp=0", k, s_ready); end
      total++; if (pdb !== 1'b1 || datatherm !== 17'h0 || datain !== 8'h00)
        begin bad++; $display("FAIL pwrup_zero cyc=%0d pdb=%b therm=%h din=%h exp pdb=1 zero", k, pdb, datatherm, datain); end
    end
    step();
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL pwrup_ready got=%b exp=1", s_ready); end
  endtask

  task automatic send_and_check(input logic [12:0] code, input logic [16:0] exp_t,
                                input logic [7:0] exp_b, input logic exp_sat);
    s_valid = 1'b1; s_code = code;
    step();
    s_valid = 1'b0;
    total++; if (datain !== exp_b)      begin bad++; $display("FAIL code_bin code=%h got=%h exp=%h", code, datain, exp_b); end
    total++; if (datatherm !== exp_t)   begin bad++; $display("FAIL code_therm code=%h got=%h exp=%h", code, datatherm, exp_t); end
    total++; if (datainb !== ~exp_b)    begin bad++; $display("FAIL code_binb code=%h got=%h exp=%h", code, datainb, ~exp_b); end
    total++; if (datathermb !== ~exp_t) begin bad++; $display("FAIL code_thermb code=%h got=%h exp=%h", code, datathermb, ~exp_t); end
    total++; if (sat !== exp_sat)       begin bad++; $display("FAIL code_sat code=%h got=%b exp=%b", code, sat, exp_sat); end
  endtask

  task automatic test_code_map();
    send_and_check(13'h05A3, 17'h0001F, 8'hA3, 1'b0);
    send_and_check(13'h1100, 17'h1FFFF, 8'h00, 1'b0);
    send_and_check(13'h0000, 17'h00000, 8'h00, 1'b0);
    send_and_check(13'h0A55, 17'h003FF, 8'h55, 1'b0);
    step();
    total++; if (datain !== 8'h55 || datatherm !== 17'h003FF)
      begin bad++; $display("FAIL code_hold got=%h/%h exp=55/003ff", datain, datatherm); end
  endtask

  task automatic test_back_to_back();
    s_valid = 1'b1; s_code = 13'h0312;
    step();
    s_code = 13'h0801;
    step();
    total++; if (datain !== 8'h01 || datatherm !== 17'h000FF)
      begin bad++; $display("FAIL b2b_second got=%h/%h exp=01/000ff", datain, datatherm); end
    s_valid = 1'b0;
  endtask

  task automatic test_saturation();
    send_and_check(13'h1FFF, 17'h1FFFF, 8'hFF, 1'b1);
    send_and_check(13'h0001, 17'h00000, 8'h01, 1'b0);
    send_and_check(13'h1200, 17'h1FFFF, 8'hFF, 1'b1);
    step();
    total++; if (sat !== 1'b0) begin bad++; $display("FAIL sat_pulse_width got=%b exp=0", sat); end
  endtask

  task automatic test_power_down();
    send_and_check(13'h0A55, 17'h003FF, 8'h55, 1'b0);
    en = 1'b0;
    step();
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL pwrdn_ready got=%b exp=0", s_ready); end
    for (int k = 0; k < 8; k++) begin
      if (k > 0) step();
      total++; if (pdb !== 1'b1 || datain !== 8'h00 || datatherm !== 17'h0 || busy !== 1'b1)
        begin bad++; $display("FAIL pwrdn_hold cyc=%0d pdb=%b din=%h therm=%h busy=%b exp 1/00/0/1", k, pdb, datain, datatherm, busy); end
    end
    step();
    total++; if (pdb !== 1'b0)  begin bad++; $display("FAIL pwrdn_pdb_fall got=%b exp=0", pdb); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL pwrdn_busy got=%b exp=0", busy); end
  endtask

  task automatic test_supply_fault();
    en = 1'b1;
    for (int k = 0; k < 17; k++) step();
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL fault_setup_ready got=%b exp=1", s_ready); end
    send_and_check(13'h0312, 17'h00007, 8'h12, 1'b0);
    supply_ok = 1'b0;
    step();
    total++; if (pdb !== 1'b0 || fault !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b0)
      begin bad++; $display("FAIL fault_trip pdb=%b fault=%b busy=%b rdy=%b exp 0/1/0/0", pdb, fault, busy, s_ready); end
    total++; if (datain !== 8'h00 || datathermb !== 17'h1FFFF)
      begin bad++; $display("FAIL fault_zero din=%h thermb=%h exp 00/1ffff", datain, datathermb); end
    supply_ok = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      total++; if (busy !== 1'b0 || fault !== 1'b1)
        begin bad++; $display("FAIL fault_stuck cyc=%0d busy=%b fault=%b exp 0/1", k, busy, fault); end
    end
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    total++; if (fault !== 1'b0 || busy !== 1'b0)
      begin bad++; $display("FAIL fault_clear fault=%b busy=%b exp 0/0", fault, busy); end
    step();
    total++; if (pdb !== 1'b1 || busy !== 1'b1)
      begin bad++; $display("FAIL fault_restart pdb=%b busy=%b exp 1/1", pdb, busy); end
    // A clear that coincides with a new loss must leave the fault set.
    supply_ok = 1'b0; fault_clr = 1'b1;
    step();
    total++; if (fault !== 1'b1 || pdb !== 1'b0)
      begin bad++; $display("FAIL fault_clr_race fault=%b pdb=%b exp 1/0", fault, pdb); end
    supply_ok = 1'b1;
    step();
    fault_clr = 1'b0;
    total++; if (fault !== 1'b0) begin bad++; $display("FAIL fault_reclear got=%b exp=0", fault); end
  endtask

  task automatic test_reset_mid();
    step();
    total++; if (pdb !== 1'b1) begin bad++; $display("FAIL rmid_enter got=%b exp=1", pdb); end
    for (int k = 0; k < 4; k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (pdb !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b0 || fault !== 1'b0 || sat !== 1'b0)
      begin bad++; $display("FAIL rmid_ctrl pdb=%b busy=%b rdy=%b fault=%b sat=%b exp all 0", pdb, busy, s_ready, fault, sat); end
    total++; if (datainb !== 8'hFF || datathermb !== 17'h1FFFF)
      begin bad++; $display("FAIL rmid_comp binb=%h thermb=%h exp ff/1ffff", datainb, datathermb); end
    step();
    total++; if (pdb !== 1'b1) begin bad++; $display("FAIL rmid_rerun_pdb got=%b exp=1", pdb); end
    for (int k = 1; k < 16; k++) begin
      step();
      total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL rmid_ready_early cyc=%0d got=%b exp=0", k, s_ready); end
    end
    step();
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready got=%b exp=1", s_ready); end
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_code_map();
    test_back_to_back();
    test_saturation();
    test_power_down();
    test_supply_fault();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
